pl3_memory: RTL

//  Memory-access pipeline stage between execute and writeback. ALU-only ops pass

---
 rtl/pl3_memory.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/pl3_memory.sv
`default_nettype none
// ============================================================================
// Module   : pl3_memory
// Purpose  : Memory-access pipeline stage between execute and writeback.
//            ALU results pass through in one cycle; loads and stores run a
//            req/ack data-memory handshake with byte-lane steering, byte
//            enables and load sign/zero extension. Upstream is stalled while
//            an access is outstanding.
// Revision : 1.0  initial release
// ============================================================================
module pl3_memory #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  input  logic [DATA_W-1:0]  i_alu_result,
  input  logic [DATA_W-1:0]  i_store_data,
  input  logic [RADDR_W-1:0] i_rd_addr,
  input  logic               i_reg_wr_en,
  input  logic               i_mem_rd,
  input  logic               i_mem_wr,
  input  logic [2:0]         i_funct3,
  output logic               o_stall,
  output logic               o_mem_req,
  output logic               o_mem_we,
  output logic [DATA_W-1:0]  o_mem_addr,
  output logic [DATA_W-1:0]  o_mem_wdata,
  output logic [3:0]         o_mem_be,
  input  logic               i_mem_ack,
  input  logic [DATA_W-1:0]  i_mem_rdata,
  output logic [DATA_W-1:0]  o_reg_wr_val,
  output logic [RADDR_W-1:0] o_reg_wr_addr,
  output logic               o_reg_wr_en,
  output logic               o_mem_fault
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  state_t               state_q;
  logic                 stall_q;
  logic                 req_q;
  logic                 we_q;
  logic [DATA_W-1:0]    addr_q;
  logic [DATA_W-1:0]    wdata_q;
  logic [3:0]           be_q;
  logic [DATA_W-1:0]    wr_val_q;
  logic [RADDR_W-1:0]   wr_addr_q;
  logic                 wr_en_q;
  logic                 fault_q;
  // Access context kept for the load-extract step when the ack arrives
  logic [2:0]           funct3_q;
  logic [1:0]           lane_q;
  logic [RADDR_W-1:0]   rd_q;

  logic                 legal_d;
  logic [DATA_W-1:0]    wdata_d;
  logic [3:0]           be_d;
  logic [DATA_W-1:0]    load_d;
  logic [7:0]           lbyte;
  logic [15:0]          lhalf;

  // Legality of the incoming access: funct3 must suit the op and address must be aligned
  always_comb begin
    legal_d = 1'b0;
    case (i_funct3)
      3'b000:  legal_d = 1'b1;
      3'b001:  legal_d = ~i_alu_result[0];
      3'b010:  legal_d = (i_alu_result[1:0] == 2'b00);
      3'b100:  legal_d = i_mem_rd;
      3'b101:  legal_d = i_mem_rd & ~i_alu_result[0];
      default: legal_d = 1'b0;
    endcase
  end

  // Store lane replication and byte enables
  always_comb begin
    wdata_d = i_store_data;
    be_d    = 4'b1111;
    case (i_funct3[1:0])
      2'b00: begin
        wdata_d = {4{i_store_data[7:0]}};
        be_d    = 4'b0001 << i_alu_result[1:0];
      end
      2'b01: begin
        wdata_d = {2{i_store_data[15:0]}};
        be_d    = i_alu_result[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wdata_d = i_store_data;
        be_d    = 4'b1111;
      end
    endcase
  end

  // Load lane selection and sign/zero extension from the latched access context
  always_comb begin
    case (lane_q)
      2'd0:    lbyte = i_mem_rdata[7:0];
      2'd1:    lbyte = i_mem_rdata[15:8];
      2'd2:    lbyte = i_mem_rdata[23:16];
      default: lbyte = i_mem_rdata[31:24];
    endcase
    lhalf = lane_q[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    case (funct3_q)
      3'b000:  load_d = {{24{lbyte[7]}}, lbyte};
      3'b001:  load_d = {{16{lhalf[15]}}, lhalf};
      3'b100:  load_d = {24'd0, lbyte};
      3'b101:  load_d = {16'd0, lhalf};
      default: load_d = i_mem_rdata;
    endcase
  end

  // Stage FSM: pass-through, request launch, ack completion and fault pulse
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      stall_q   <= 1'b0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= 4'b0000;
      wr_val_q  <= '0;
      wr_addr_q <= '0;
      wr_en_q   <= 1'b0;
      fault_q   <= 1'b0;
      funct3_q  <= 3'b000;
      lane_q    <= 2'b00;
      rd_q      <= '0;
    end else begin
      fault_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_valid && (i_mem_rd || i_mem_wr)) begin
            wr_en_q <= 1'b0;
            if (legal_d) begin
              state_q  <= ST_ACCESS;
              stall_q  <= 1'b1;
              req_q    <= 1'b1;
              we_q     <= i_mem_wr;
              addr_q   <= {i_alu_result[DATA_W-1:2], 2'b00};
              wdata_q  <= i_mem_wr ? wdata_d : '0;
              be_q     <= i_mem_wr ? be_d : 4'b0000;
              funct3_q <= i_funct3;
              lane_q   <= i_alu_result[1:0];
              rd_q     <= i_rd_addr;
            end else begin
              fault_q  <= 1'b1;
            end
          end else if (i_valid) begin
            wr_val_q  <= i_alu_result;
            wr_addr_q <= i_rd_addr;
            wr_en_q   <= i_reg_wr_en & (i_rd_addr != '0);
          end else begin
            wr_en_q   <= 1'b0;
          end
        end
        ST_ACCESS: begin
          wr_en_q <= 1'b0;
          if (i_mem_ack) begin
            state_q <= ST_IDLE;
            stall_q <= 1'b0;
            req_q   <= 1'b0;
            if (!we_q) begin
              wr_val_q  <= load_d;
              wr_addr_q <= rd_q;
              wr_en_q   <= (rd_q != '0);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_stall       = stall_q;
  assign o_mem_req     = req_q;
  assign o_mem_we      = we_q;
  assign o_mem_addr    = addr_q;
  assign o_mem_wdata   = wdata_q;
  assign o_mem_be      = be_q;
  assign o_reg_wr_val  = wr_val_q;
  assign o_reg_wr_addr = wr_addr_q;
  assign o_reg_wr_en   = wr_en_q;
  assign o_mem_fault   = fault_q;

endmodule
`default_nettype wire
